// File: rtl/memory_stage_pkg.sv
// Processor-wide defines shared by the pipeline stages: memory access
// size (funct3) and writeback result selection.
package memory_stage_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } result_src_t;

endpackage

// File: rtl/memory_stage_align.sv
// Byte-lane steering for the data-memory port: store byte enables and
// replicated write data, plus load lane extraction and extension.
module load_store_align
    import memory_stage_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  mem_size_t   size,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  store_be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    function automatic logic [31:0] sext8(input logic signed [7:0] v);
        logic signed [31:0] r;
        r = v;
        return r;
    endfunction

    function automatic logic [31:0] sext16(input logic signed [15:0] v);
        logic signed [31:0] r;
        r = v;
        return r;
    endfunction

    logic [31:0] lane;
    assign lane = rdata >> {addr_lo, 3'b000};

    always_comb begin
        store_be  = 4'h0;
        wdata     = store_data;
        load_data = rdata;
        case (size)
            MEM_B, MEM_BU: begin
                store_be  = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = (size == MEM_B) ? sext8(lane[7:0]) : {24'h0, lane[7:0]};
            end
            MEM_H, MEM_HU: begin
                store_be  = 4'b0011 << {addr_lo[1], 1'b0};
                wdata     = {2{store_data[15:0]}};
                load_data = (size == MEM_H) ? sext16(lane[15:0]) : {16'h0, lane[15:0]};
            end
            MEM_W: begin
                store_be  = 4'hF;
                wdata     = store_data;
                load_data = rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// M stage of the RV32I pipeline: E->M register, data-memory handshake with
// wait-state stall and timeout abort, load/store formatting.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] e_alu_result,
    input  logic [31:0] e_write_data,
    input  logic [4:0]  e_rd,
    input  logic [31:0] e_pc_plus_4,
    input  logic        e_reg_write,
    input  result_src_t e_result_src,
    input  logic        e_mem_read,
    input  logic        e_mem_write,
    input  mem_size_t   e_mem_size,
    output logic        m_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] m_alu_result,
    output logic [31:0] m_read_data,
    output logic [4:0]  m_rd,
    output logic [31:0] m_pc_plus_4,
    output logic        m_reg_write,
    output result_src_t m_result_src,
    output logic        m_misaligned,
    output logic        m_bus_error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state;
    logic [CNT_W-1:0] cnt_p0, cnt_inc;
    logic        timeout_p0, arm_timeout;
    logic        mem_read_p0, mem_write_p0;
    mem_size_t   mem_size_p0;
    logic [31:0] write_data_p0;
    logic        e_misaligned, access, active;
    logic [3:0]  store_be;
    logic [31:0] store_wdata, load_data;

    function automatic logic misaligned_fn(input mem_size_t size, input logic [1:0] lo);
        case (size[1:0])
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Alignment is judged on the E-side values so the flag is a plain register in M.
    assign e_misaligned = (e_mem_read | e_mem_write) & misaligned_fn(e_mem_size, e_alu_result[1:0]);

    assign access      = mem_read_p0 | mem_write_p0;
    assign active      = access & ~m_misaligned & ~timeout_p0;
    assign m_stall     = active & ~dmem_ready;
    assign dmem_req    = active;
    assign dmem_we     = active & mem_write_p0;
    assign dmem_addr   = {m_alu_result[31:2], 2'b00};
    assign dmem_be     = mem_write_p0 ? store_be : 4'hF;
    assign dmem_wdata  = store_wdata;
    assign m_read_data = (active & mem_read_p0 & dmem_ready) ? load_data : 32'h0;
    assign m_bus_error = timeout_p0;

    // Timeout is decided one cycle early so the abort cycle drops the request cleanly.
    assign cnt_inc     = (cnt_p0 == CNT_MAX) ? cnt_p0 : cnt_p0 + 1'b1;
    assign arm_timeout = m_stall & ((state == IDLE) ? (CNT_MAX == CNT_W'(1)) : (cnt_inc == CNT_MAX));

    load_store_align u_align (
        .addr_lo    (m_alu_result[1:0]),
        .size       (mem_size_p0),
        .store_data (write_data_p0),
        .rdata      (dmem_rdata),
        .store_be   (store_be),
        .wdata      (store_wdata),
        .load_data  (load_data)
    );

    // E -> M register
    always_ff @(posedge clk) begin
        if (reset) begin
            m_alu_result  <= '0;
            write_data_p0 <= '0;
            m_rd          <= '0;
            m_pc_plus_4   <= '0;
            m_reg_write   <= 1'b0;
            m_result_src  <= RES_ALU;
            mem_read_p0   <= 1'b0;
            mem_write_p0  <= 1'b0;
            mem_size_p0   <= MEM_B;
            m_misaligned  <= 1'b0;
        end else if (!m_stall) begin
            m_alu_result  <= e_alu_result;
            write_data_p0 <= e_write_data;
            m_rd          <= e_rd;
            m_pc_plus_4   <= e_pc_plus_4;
            m_reg_write   <= e_reg_write & ~e_misaligned;
            m_result_src  <= e_result_src;
            mem_read_p0   <= e_mem_read;
            mem_write_p0  <= e_mem_write;
            mem_size_p0   <= e_mem_size;
            m_misaligned  <= e_misaligned;
        end else if (arm_timeout) begin
            m_reg_write   <= 1'b0;
        end
    end

    // Access FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt_p0     <= '0;
            timeout_p0 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_stall) begin
                        state      <= WAIT;
                        cnt_p0     <= CNT_W'(1);
                        timeout_p0 <= arm_timeout;
                    end
                end
                WAIT: begin
                    if (timeout_p0 || dmem_ready) begin
                        state      <= IDLE;
                        cnt_p0     <= '0;
                        timeout_p0 <= 1'b0;
                    end else begin
                        cnt_p0     <= cnt_inc;
                        timeout_p0 <= arm_timeout;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
